round_robin_arbiter_8: RTL and testbench

ROUND_ROBIN_ARBITER_8 -- requirements
Module: round_robin_arbiter_8

---
 rtl/round_robin_arbiter_8.sv | 100 ++++++++++
 tb/tb_round_robin_arbiter_8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter_8.sv
// round_robin_arbiter_8: 8-way round-robin arbiter, two-state FSM, no preemption.
// Optional hold-time limit with timeout_flag pulse is enabled by defining ARB_TIMEOUT_EN.
module round_robin_arbiter_8 #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_lines,
  input  logic       done,
  output logic [7:0] grant_lines,
  output logic [2:0] grant_index,
  output logic       grant_valid,
  output logic       timeout_flag
);
  // state | meaning
  // IDLE  | no grant held; arbitrate req_lines starting at r_rr_ptr
  // GRANT | r_grant_index owns the grant until done, request drop or timeout
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  state_t     r_state;
  logic [2:0] r_rr_ptr;
  logic [2:0] r_grant_index;
  logic [7:0] r_grant_lines;
  logic       r_grant_valid;
  logic       r_timeout_flag;
  logic [2:0] w_pick;
  logic       w_normal_rel;
  logic       w_forced_rel;

  // Scan from the farthest offset down so the nearest set bit at/after r_rr_ptr wins.
  always_comb begin
    w_pick = r_rr_ptr;
    for (int k = 7; k >= 0; k--) begin
      if (req_lines[r_rr_ptr + 3'(k)]) w_pick = r_rr_ptr + 3'(k);
    end
  end

  assign w_normal_rel = done | ~req_lines[r_grant_index];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;

  // Held at zero in IDLE so it reads zero on the first GRANT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign w_forced_rel = (r_state == GRANT) && (r_hold_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign w_forced_rel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_grant_index  <= '0;
      r_grant_lines  <= '0;
      r_grant_valid  <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout_flag <= 1'b0;
          if (|req_lines) begin
            r_state       <= GRANT;
            r_grant_index <= w_pick;
            r_grant_lines <= 8'd1 << w_pick;
            r_grant_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (w_normal_rel || w_forced_rel) begin
            r_state        <= IDLE;
            r_rr_ptr       <= r_grant_index + 3'd1;
            r_grant_index  <= '0;
            r_grant_lines  <= '0;
            r_grant_valid  <= 1'b0;
            r_timeout_flag <= w_forced_rel & ~w_normal_rel;
          end
        end
      endcase
    end
  end

  assign grant_lines  = r_grant_lines;
  assign grant_index  = r_grant_index;
  assign grant_valid  = r_grant_valid;
  assign timeout_flag = r_timeout_flag;
endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Testbench for round_robin_arbiter_8: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the arbitration rules.
module tb_round_robin_arbiter_8;
  localparam int T = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_lines;
  logic       done;
  logic [7:0] grant_lines;
  logic [2:0] grant_index;
  logic       grant_valid;
  logic       timeout_flag;

  int total = 0;
  int bad = 0;

  round_robin_arbiter_8 #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_lines(req_lines), .done(done),
    .grant_lines(grant_lines), .grant_index(grant_index),
    .grant_valid(grant_valid), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the grant, where the search starts, how long it has been held.
  bit m_started = 1'b0;
  bit m_valid   = 1'b0;
  int m_idx     = 0;
  int m_ptr     = 0;
  int m_held    = 0;
  bit m_flag    = 1'b0;

  always @(posedge clk) begin
    bit found, normal, forced;
    m_started = 1'b1;
    if (!rst_n) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_flag = 0;
    end else if (!m_valid) begin
      m_flag = 0;
      if (req_lines != 8'h00) begin
        found = 0;
        for (int k = 0; k < 8; k++) begin
          if (!found && req_lines[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            found = 1;
          end
        end
        m_valid = 1;
        m_held = 0;
      end
    end else begin
      m_held++;
      normal = done || !req_lines[m_idx];
      forced = TO_EN && (m_held >= T);
      if (normal || forced) begin
        m_ptr   = (m_idx + 1) % 8;
        m_flag  = forced && !normal;
        m_valid = 0;
        m_idx   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_valid", grant_valid, m_valid);
      chk("model_index", grant_index, m_idx);
      chk("model_lines", grant_lines, m_valid ? (8'h01 << m_idx) : 8'h00);
      chk("model_tflag", timeout_flag, m_flag);
      chk("onehot", ($countones(grant_lines) <= 1), 1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string name, input int idx);
    chk({name, "_valid"}, grant_valid, 1);
    chk({name, "_index"}, grant_index, idx);
    chk({name, "_lines"}, grant_lines, 8'h01 << idx);
    chk({name, "_mvalid"}, m_valid, 1);
    chk({name, "_midx"}, m_idx, idx);
  endtask

  task automatic expect_idle(input string name, input bit flag);
    chk({name, "_valid"}, grant_valid, 0);
    chk({name, "_lines"}, grant_lines, 8'h00);
    chk({name, "_tflag"}, timeout_flag, flag);
    chk({name, "_mflag"}, m_flag, flag);
  endtask

  initial begin
    rst_n = 1'b0; req_lines = 8'h00; done = 1'b0;
    cyc(); cyc();
    expect_idle("reset", 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_idle("idle_noreq", 0);
    end

    // first set bit from ptr 0, then continue from 3
    req_lines = 8'h24;
    cyc(); expect_grant("req24_first", 2);
    done = 1'b1;
    cyc(); expect_idle("req24_rel", 0);
    done = 1'b0;
    cyc(); expect_grant("req24_second", 5);
    req_lines = 8'h00;
    cyc(); expect_idle("req24_drop", 0);
    cyc();

    // full rotation with done held high
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    req_lines = 8'hFF; done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc(); expect_grant("rotate", k % 8);
      cyc(); expect_idle("rotate_gap", 0);
    end

    // wrap 7 -> 0 -> 7
    req_lines = 8'h80; done = 1'b0;
    cyc(); expect_grant("wrap_g7", 7);
    req_lines = 8'h81; done = 1'b1;
    cyc(); expect_idle("wrap_rel7", 0);
    done = 1'b0;
    cyc(); expect_grant("wrap_g0", 0);
    done = 1'b1;
    cyc(); expect_idle("wrap_rel0", 0);
    done = 1'b0;
    cyc(); expect_grant("wrap_g7b", 7);
    done = 1'b1;
    cyc(); expect_idle("wrap_rel7b", 0);
    done = 1'b0; req_lines = 8'h00;
    cyc();

    // hold without done: timeout or indefinite hold
    req_lines = 8'h08;
    cyc(); expect_grant("hold_g", 3);
    if (TO_EN) begin
      for (int i = 0; i < T - 1; i++) begin
        cyc(); expect_grant("hold_to", 3);
      end
      cyc(); expect_idle("timeout", 1);
      cyc(); expect_grant("regrant", 3);
      chk("regrant_tflag", timeout_flag, 0);
    end else begin
      for (int i = 0; i < 100; i++) begin
        cyc(); expect_grant("hold_forever", 3);
      end
    end
    req_lines = 8'h00;
    cyc(); expect_idle("hold_drop", 0);

    // done on the last allowed cycle counts as a normal release
    req_lines = 8'h08;
    cyc(); expect_grant("same_g", 3);
    cyc(); cyc(); cyc();
    expect_grant("same_g4", 3);
    done = 1'b1;
    cyc(); expect_idle("same_rel", 0);
    done = 1'b0; req_lines = 8'h00;
    cyc(); expect_idle("same_after", 0);

    // reset while index 6 holds the grant
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    req_lines = 8'h40;
    cyc(); expect_grant("rst_g6", 6);
    rst_n = 1'b0; req_lines = 8'h41;
    cyc(); expect_idle("rst_in_grant", 0);
    rst_n = 1'b1;
    cyc(); expect_grant("rst_after", 0);
    req_lines = 8'h00;
    cyc();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: req_lines = 8'h00;
        1: req_lines = 8'h01 << $urandom_range(0, 7);
        default: req_lines = 8'($urandom);
      endcase
      done  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end
    rst_n = 1'b1; req_lines = 8'h00; done = 1'b0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
